// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-store buffer.
// Entry layout is {word address, byte enables, lane-positioned data}.
package store_buffer_pkg;

    localparam int STB_DEPTH = 4;
    localparam int STB_LANES = 4;
    localparam int STB_AW    = 32;
    localparam int STB_WA_W  = STB_AW - 2;
    localparam int STB_DW    = 8 * STB_LANES;

    typedef struct packed {
        logic [STB_WA_W-1:0]  waddr;
        logic [STB_LANES-1:0] byteen;
        logic [STB_DW-1:0]    wdata;
    } stb_entry_t;

    // Expands lane enables into a bit mask over the data word.
    function automatic logic [STB_DW-1:0] byteen_to_mask(input logic [STB_LANES-1:0] be);
        logic [STB_DW-1:0] mask;
        mask = '0;
        for (int l = 0; l < STB_LANES; l++) begin
            mask[8*l +: 8] = {8{be[l]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/stb_fwd_merge.sv
// Age-ordered, per-lane priority merge of buffered stores onto a load word.
// Entries are walked oldest to youngest so the youngest matching byte wins.
module stb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH
) (
    input  stb_entry_t                 entries_i [DEPTH],
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr_i,
    input  logic [STB_WA_W-1:0]        ld_waddr_i,
    output logic [STB_LANES-1:0]       fwd_byteen_o,
    output logic [STB_DW-1:0]          fwd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  idx;
    logic [STB_DW-1:0] mask;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        fwd_byteen_o = '0;
        fwd_data_o   = '0;
        idx          = '0;
        mask         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_i + PTR_W'(k);
            if (valid_i[idx] && (entries_i[idx].waddr == ld_waddr_i)) begin
                mask         = byteen_to_mask(entries_i[idx].byteen);
                fwd_data_o   = (fwd_data_o & ~mask) | (entries_i[idx].wdata & mask);
                fwd_byteen_o = fwd_byteen_o | entries_i[idx].byteen;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between the store formatter and the data-memory port,
// with a zero-cycle load lookup. Define STB_FWD_EN to enable byte forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int AW    = STB_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [AW-1:0]        in_addr,
    input  logic [STB_LANES-1:0] in_byteen,
    input  logic [STB_DW-1:0]    in_wdata,
    output logic                 in_ready,
    output logic                 mem_valid,
    output logic [AW-1:0]        mem_addr,
    output logic [STB_LANES-1:0] mem_byteen,
    output logic [STB_DW-1:0]    mem_wdata,
    input  logic                 mem_ready,
    input  logic [AW-1:0]        ld_addr,
    output logic                 ld_conflict,
    output logic [STB_LANES-1:0] ld_fwd_byteen,
    output logic [STB_DW-1:0]    ld_fwd_data,
    output logic                 empty,
    output logic                 full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    stb_entry_t          entries_q [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                push, pop;
    stb_entry_t          in_entry, head;
    logic [STB_WA_W-1:0] ld_waddr;
    logic                unused_addr_lsbs;

    // Addresses are word-granular; the byte offset is carried by the enables.
    assign unused_addr_lsbs = ^{in_addr[1:0], ld_addr[1:0]};

    assign in_entry = '{waddr:  STB_WA_W'(in_addr[AW-1:2]),
                        byteen: in_byteen,
                        wdata:  in_wdata};
    assign ld_waddr = STB_WA_W'(ld_addr[AW-1:2]);
    assign head     = entries_q[rd_ptr_q];

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign mem_valid  = !empty;
    assign mem_addr   = {head.waddr[AW-3:0], 2'b00};
    assign mem_byteen = head.byteen;
    assign mem_wdata  = head.wdata;

    // An all-zero byteen store is consumed without occupying an entry.
    assign push = in_valid && in_ready && (in_byteen != '0);
    assign pop  = mem_valid && mem_ready;

    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the small entry array is reset so mem_* read zero after reset without output gating.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                entries_q[wr_ptr_q] <= in_entry;
            end
        end
    end

    // The head entry still counts while it is being retired this cycle.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entries_q[i].waddr == ld_waddr)) begin
                ld_conflict = 1'b1;
            end
        end
    end

`ifdef STB_FWD_EN
    stb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd_merge (
        .entries_i    (entries_q),
        .valid_i      (valid_q),
        .rd_ptr_i     (rd_ptr_q),
        .ld_waddr_i   (ld_waddr),
        .fwd_byteen_o (ld_fwd_byteen),
        .fwd_data_o   (ld_fwd_data)
    );
`else
    assign ld_fwd_byteen = '0;
    assign ld_fwd_data   = '0;
`endif

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the store formatter and the external data-memory port. It captures each formatted store (word-aligned address, byte enables, lane-positioned write data) in a small FIFO and drains it to memory over a valid/ready handshake, so the pipeline does not wait on memory. Loads can look into the buffer: every load reports a conflict with any pending store, and can optionally be served by byte-wise forwarding.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  store offered by the formatter this cycle
- in_addr  in  AW  store byte address; bits [1:0] ignored
- in_byteen  in  4  lane byte enables (bit i = byte lane i)
- in_wdata  in  32  lane-positioned write data
- in_ready  out  1  buffer can accept; equals !full
- mem_valid  out  1  head entry presented to memory
- mem_addr  out  AW  head address, {addr[AW-1:2],2'b00}
- mem_byteen  out  4  head byte enables
- mem_wdata  out  32  head write data
- mem_ready  in  1  memory accepts head this cycle
- ld_addr  in  AW  address of the load in MEM stage
- ld_conflict  out  1  any valid entry has the same word address as ld_addr
- ld_fwd_byteen  out  4  lanes supplied by the buffer (forwarding only)
- ld_fwd_data  out  32  forwarded lane data (forwarding only)
- empty  out  1  no valid entries
- full  out  1  count == DEPTH

## Operation
- Enqueue: in_valid && in_ready && in_byteen != 0 writes {word addr, byteen, wdata} at wr_ptr. in_valid with byteen == 0 is a no-op: no entry is written and the request is treated as consumed.
- Dequeue: mem_valid && mem_ready retires the head entry and advances rd_ptr.
- Pointers are log2(DEPTH) bits, wrap naturally, and the count is log2(DEPTH)+1 bits.
- Same cycle enqueue and dequeue: count is unchanged and both pointers advance.
- Full: in_ready = 0 even if a dequeue happens in the same cycle (no pass-through on dequeue).
- Empty: mem_valid = 0, and there is no bypass from input to memory.
- Stores are kept in order and never merged.
- mem_* outputs stay stable while mem_valid && !mem_ready.
- ld_conflict is purely combinational. It compares ld_addr[AW-1:2] against every valid entry, and the entry being dequeued in the current cycle still counts.
- The pipeline stalls the load while ld_conflict is set, unless forwarding covers every byte the load needs; that decision belongs to the hazard unit, not to this block.

## Timing
- Reset values: count = 0, pointers = 0, all entries invalid. Therefore empty = 1, full = 0, in_ready = 1, mem_valid = 0, mem_addr/mem_byteen/mem_wdata = 0, ld_conflict = 0, ld_fwd_byteen = 0, ld_fwd_data = 0.
- Latency: a store accepted at edge N appears on mem_valid in the cycle after edge N, when the buffer was empty.
- Throughput: one enqueue and one dequeue per cycle.
- Reset asserted mid-operation drops all pending entries immediately (asynchronous). mem_valid falls without a handshake, and the memory side must tolerate this.
- Load lookup is zero-cycle: the outputs follow ld_addr and the buffer state in the same cycle.

## Configuration
- STB_FWD_EN defined: ld_fwd_byteen and ld_fwd_data are computed by scanning valid entries from oldest to youngest. For each lane, the youngest word-address-matching entry with that byte enabled supplies the byte, and ld_fwd_byteen is the OR of the matching enables.
- STB_FWD_EN undefined: ld_fwd_byteen = 0 and ld_fwd_data = 0 permanently. ld_conflict is unaffected.

## Structure
- Shared package holds:
  - the entry struct {word address, byteen[3:0], wdata[31:0]}
  - the STB_DEPTH default
  - the lane-width constant 4
- Sub-module stb_fwd_merge: an age-ordered, per-lane priority merge over the entry array. It is instantiated only under STB_FWD_EN.

## Test plan
- Reset, then stores (0x100, 4'b1111, 0xDEADBEEF) and (0x204, 4'b0011, 0x0000BEEF) with mem_ready = 1 -> memory sees both stores, in order, one cycle after each is accepted; empty returns to 1.
- With mem_ready = 0, offer 5 stores at DEPTH = 4 -> full = 1 and in_ready = 0 after the 4th; the 5th is held off; the head stays stable; releasing mem_ready drains all four in order.
- Full buffer, then simultaneous dequeue and an offered enqueue -> the enqueue is rejected that cycle and accepted the next; pointer wrap-around keeps FIFO order.
- Pending (0x300, 4'b0001, 0x000000AA) then (0x301, 4'b0010, 0x0000BB00); ld_addr = 0x300 -> ld_conflict = 1. With STB_FWD_EN: ld_fwd_byteen = 4'b0011 and ld_fwd_data = 0x0000BBAA. Without it: both are 0.
- Two pending stores to 0x400 with lane-0 data 0x11 then 0x22 -> the forwarded byte is 0x22 (youngest wins).
- Reset pulsed while 3 entries are pending and mem_valid = 1 -> empty = 1, mem_valid = 0 and ld_conflict = 0 immediately; in_valid with byteen = 0 creates no entry.
